adxl362_spi_responder: RTL and testbench
========================================

# adxl362_spi_responder

Synthesizable SPI responder that plays the accelerometer end of the SPI link, so the existing SPI master and its controller can be exercised in simulation and on-board loopback without the physical ADXL362. It decodes the ADXL362 register-access protocol (0x0A write, 0x0B read, auto-increment addressing) and serves a 64-byte register map. Sample registers are loaded from parallel test inputs, and the block drives the int1/int2 lines that the FPGA top consumes.

## Interface
- DEVID_AD, 8'hAD, value at 0x00
- DEVID_MST, 8'h1D, value at 0x01
- PARTID, 8'hF2, value at 0x02
- REVID, 8'h01, value at 0x03
- clk  in  1  system clock; must be at least 4× the sck_i frequency
- nrst  in  1  reset, asynchronous, active-low
- sck_i  in  1  SPI clock from master, mode 0 (CPOL=0, CPHA=0)
- ncs_i  in  1  chip select, active-low
- mosi_i  in  1  serial data from master, MSB first
- miso_o  out  1  serial data to master; 0 whenever not shifting read data
- x_i, y_i, z_i, temp_i  in  12 each  two's-complement sample values
- sample_valid_i  in  1  one-clk pulse; x/y/z/temp inputs are valid
- int1_o, int2_o  out  1  interrupt pins
- measure_o  out  1  1 when POWER_CTL[1:0]==2'b10

## Operation
- sck_i, ncs_i and mosi_i each pass through a 2-flop synchronizer, followed by a delay flop for edge detection. All logic runs on clk.
- mosi is sampled on the detected sck rising edge. miso shifts on the detected sck falling edge.
- FSM states: IDLE, CMD, ADDR, WDATA, RDATA, IGNORE.
  - IDLE→CMD on ncs falling edge. The bit counter clears.
  - CMD: after the 8th rising edge, 0x0A→ADDR(write) and 0x0B→ADDR(read). Any other value→IGNORE.
  - ADDR: after the 8th rising edge, latch addr[5:0]; bits [7:6] are ignored.
    - Write: go to WDATA.
    - Read: load the read shift register from reg[addr], increment addr, go to RDATA.
  - WDATA: on the 8th rising edge of each byte, commit the byte to addr, then increment addr.
  - RDATA: the MSB of the loaded byte drives miso on the falling edge that follows the load. On the 8th rising edge of each byte, load the next byte and increment addr.
  - IGNORE: miso stays 0 until ncs rises.
  - Any state→IDLE on ncs rising edge. A partial byte is discarded with no commit.
- The address wraps 0x3F→0x00.
- Register map (unlisted addresses read 0x00, and writes to them are ignored):
  - 0x00–0x03: ID parameters; read-only.
  - 0x0B STATUS: bit0 = DATA_READY; read-only.
  - 0x0E/0x0F: X_L = x[7:0], X_H = {4{x[11]}, x[11:8]}.
  - 0x10/0x11: Y, same layout as X.
  - 0x12/0x13: Z, same layout as X.
  - 0x14/0x15: TEMP, same layout as X.
  - 0x1F SOFT_RESET: write-only, reads 0x00. Writing 0x52 clears 0x20–0x2E and DATA_READY. Any other value has no effect.
  - 0x20–0x2E: R/W storage. 0x2A = INTMAP1, 0x2B = INTMAP2, 0x2D = POWER_CTL.
- Sample update: sample_valid_i latches x/y/z/temp and sets DATA_READY, but only while the synchronized ncs is high.
  - If ncs is low, the sample is held in a pending buffer (the newest sample wins) and applied 1 clk after ncs rises. This keeps a burst read coherent.
- DATA_READY is cleared when a read byte is loaded from any of 0x0E–0x15. If set and clear happen in the same clk, set wins.
- int1_o = INTMAP1[7] ^ (INTMAP1[0] & DATA_READY), registered. int2_o is the same using INTMAP2.

## Timing
- Reset values:
  - miso_o = 0, int1_o = 0, int2_o = 0, measure_o = 0.
  - FSM = IDLE; all storage, sample registers and DATA_READY = 0.
- Internal edge-detect latency is 3 clk from a pin edge.
- miso_o updates within 4 clk of a sck_i falling edge, so it is valid before the next rising edge at the minimum 4× ratio.
- A write commit is visible in the register file 1 clk after the detected 8th rising edge.
- int1_o and int2_o follow DATA_READY and INTMAP changes with 1 clk latency.
- An asynchronous reset mid-transaction returns to IDLE immediately. If ncs is still low, the rest of that frame is ignored until ncs goes high and then low again.

## Test plan
- Read ID burst: ncs low, send 0x0B 0x00 plus 4 dummy bytes → miso returns 0xAD 0x1D 0xF2 0x01.
- Write then read: write 0x2D=0x02 and 0x2A=0x01, then read them back → 0x02 and 0x01 returned; measure_o=1.
- Sample and interrupt:
  - Pulse sample_valid_i with x=0x801, temp=0x0FF → int1_o=1.
  - Read 0x0E–0x0F → 0x01, 0xF8; int1_o=0.
  - Read 0x14–0x15 → 0xFF, 0x00.
- Coherency: during a burst read of 0x0E, pulse sample_valid_i with new data → the old values are returned; the new values appear in a read after ncs rises; DATA_READY=1.
- Wraparound and error cases:
  - Write burst starting at 0x3F → the second byte lands at 0x00 and is ignored.
  - Command 0x0D → miso=0 for the whole frame.
  - ncs rises after 5 bits of a write byte → no register changes.
- Soft reset: write 0x1F=0x52 → 0x20–0x2E read 0x00 and int1_o=0. Write 0x1F=0x51 → no change.

Source files
------------

// File: rtl/adxl362_spi_responder.sv
// ADXL362 SPI slave model: decodes 0x0A/0x0B register access with
// auto-increment, serves a 64-byte register map, loads sample registers
// from parallel inputs and drives the int1/int2/measure lines.
module adxl362_spi_responder #(
    parameter logic [7:0] DEVID_AD  = 8'hAD,
    parameter logic [7:0] DEVID_MST = 8'h1D,
    parameter logic [7:0] PARTID    = 8'hF2,
    parameter logic [7:0] REVID     = 8'h01
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        sck_i,
    input  logic        ncs_i,
    input  logic        mosi_i,
    output logic        miso_o,
    input  logic [11:0] x_i,
    input  logic [11:0] y_i,
    input  logic [11:0] z_i,
    input  logic [11:0] temp_i,
    input  logic        sample_valid_i,
    output logic        int1_o,
    output logic        int2_o,
    output logic        measure_o
);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, WDATA, RDATA, IGNORE} state_e;

    // [0]/[1] synchronizer, [2] delay flop for edge detection
    logic [2:0]  sck_pipe_q, sck_pipe_d;
    logic [2:0]  ncs_pipe_q, ncs_pipe_d;
    logic [1:0]  mosi_pipe_q, mosi_pipe_d;

    state_e      state_q, state_d;
    logic        is_rd_q, is_rd_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [6:0]  shift_in_q, shift_in_d;
    logic [5:0]  addr_q, addr_d;
    logic [7:0]  rd_shift_q, rd_shift_d;
    logic        miso_q, miso_d;
    // R/W storage for 0x20-0x2F, indexed by addr[3:0]; 0x2F is never written
    logic [7:0]  rw_q [0:15];
    logic [7:0]  rw_d [0:15];
    logic [11:0] x_q, x_d, y_q, y_d, z_q, z_d, t_q, t_d;
    logic [11:0] px_q, px_d, py_q, py_d, pz_q, pz_d, pt_q, pt_d;
    logic        pend_q, pend_d;
    logic        dr_q, dr_d;
    logic        int1_q, int1_d, int2_q, int2_d;

    logic        sck_rise, sck_fall, ncs_rise, ncs_fall, ncs_s;
    logic [7:0]  byte_in;
    logic [5:0]  load_addr;
    logic [7:0]  rd_byte;

    assign sck_rise = sck_pipe_q[1] & ~sck_pipe_q[2];
    assign sck_fall = ~sck_pipe_q[1] & sck_pipe_q[2];
    assign ncs_rise = ncs_pipe_q[1] & ~ncs_pipe_q[2];
    assign ncs_fall = ~ncs_pipe_q[1] & ncs_pipe_q[2];
    assign ncs_s    = ncs_pipe_q[1];
    assign byte_in  = {shift_in_q, mosi_pipe_q[1]};

    // Address of a read load: the just-received address byte, else the running pointer
    assign load_addr = (state_q == ADDR) ? byte_in[5:0] : addr_q;

    // Register map read mux
    always_comb begin
        rd_byte = 8'h00;
        case (load_addr)
            6'h00:   rd_byte = DEVID_AD;
            6'h01:   rd_byte = DEVID_MST;
            6'h02:   rd_byte = PARTID;
            6'h03:   rd_byte = REVID;
            6'h0B:   rd_byte = {7'b0, dr_q};
            6'h0E:   rd_byte = x_q[7:0];
            6'h0F:   rd_byte = {{4{x_q[11]}}, x_q[11:8]};
            6'h10:   rd_byte = y_q[7:0];
            6'h11:   rd_byte = {{4{y_q[11]}}, y_q[11:8]};
            6'h12:   rd_byte = z_q[7:0];
            6'h13:   rd_byte = {{4{z_q[11]}}, z_q[11:8]};
            6'h14:   rd_byte = t_q[7:0];
            6'h15:   rd_byte = {{4{t_q[11]}}, t_q[11:8]};
            default: if (load_addr >= 6'h20 && load_addr <= 6'h2E) rd_byte = rw_q[load_addr[3:0]];
        endcase
    end

    // Next-state: SPI protocol FSM, register writes, sample capture, interrupts
    always_comb begin
        logic dr_set, dr_clr, rd_load;
        sck_pipe_d  = {sck_pipe_q[1:0], sck_i};
        ncs_pipe_d  = {ncs_pipe_q[1:0], ncs_i};
        mosi_pipe_d = {mosi_pipe_q[0], mosi_i};
        state_d    = state_q;
        is_rd_d    = is_rd_q;
        bit_cnt_d  = bit_cnt_q;
        shift_in_d = shift_in_q;
        addr_d     = addr_q;
        rd_shift_d = rd_shift_q;
        miso_d     = miso_q;
        rw_d       = rw_q;
        x_d = x_q;   y_d = y_q;   z_d = z_q;   t_d = t_q;
        px_d = px_q; py_d = py_q; pz_d = pz_q; pt_d = pt_q;
        pend_d     = pend_q;
        dr_set     = 1'b0;
        dr_clr     = 1'b0;
        rd_load    = 1'b0;

        if (ncs_rise) begin
            // Frame end: any partial byte is simply dropped
            state_d   = IDLE;
            bit_cnt_d = 3'd0;
            miso_d    = 1'b0;
        end else if (ncs_fall && state_q == IDLE) begin
            state_d   = CMD;
            bit_cnt_d = 3'd0;
            miso_d    = 1'b0;
        end else begin
            if (sck_rise && (state_q == CMD || state_q == ADDR ||
                             state_q == WDATA || state_q == RDATA)) begin
                shift_in_d = byte_in[6:0];
                bit_cnt_d  = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    case (state_q)
                        CMD: begin
                            if (byte_in == 8'h0A) begin
                                state_d = ADDR; is_rd_d = 1'b0;
                            end else if (byte_in == 8'h0B) begin
                                state_d = ADDR; is_rd_d = 1'b1;
                            end else begin
                                state_d = IGNORE;
                            end
                        end
                        ADDR: begin
                            if (is_rd_q) begin
                                rd_load = 1'b1;
                                state_d = RDATA;
                            end else begin
                                addr_d  = byte_in[5:0];
                                state_d = WDATA;
                            end
                        end
                        WDATA: begin
                            if (addr_q == 6'h1F) begin
                                if (byte_in == 8'h52) begin
                                    for (int i = 0; i < 16; i++) rw_d[i] = 8'h00;
                                    dr_clr = 1'b1;
                                end
                            end else if (addr_q >= 6'h20 && addr_q <= 6'h2E) begin
                                rw_d[addr_q[3:0]] = byte_in;
                            end
                            addr_d = addr_q + 6'd1;
                        end
                        default: rd_load = 1'b1;  // RDATA
                    endcase
                end
            end
            if (rd_load) begin
                rd_shift_d = rd_byte;
                addr_d     = load_addr + 6'd1;
                if (load_addr >= 6'h0E && load_addr <= 6'h15) dr_clr = 1'b1;
            end
            if (sck_fall) begin
                if (state_q == RDATA) begin
                    miso_d     = rd_shift_q[7];
                    rd_shift_d = {rd_shift_q[6:0], 1'b0};
                end else begin
                    miso_d = 1'b0;
                end
            end
        end

        // Samples only land while no frame is active so burst reads stay coherent
        if (sample_valid_i && ncs_s) begin
            x_d = x_i; y_d = y_i; z_d = z_i; t_d = temp_i;
            pend_d = 1'b0;
            dr_set = 1'b1;
        end else if (sample_valid_i) begin
            px_d = x_i; py_d = y_i; pz_d = z_i; pt_d = temp_i;
            pend_d = 1'b1;
        end else if (pend_q && ncs_s) begin
            x_d = px_q; y_d = py_q; z_d = pz_q; t_d = pt_q;
            pend_d = 1'b0;
            dr_set = 1'b1;
        end

        dr_d = dr_q;
        if (dr_clr) dr_d = 1'b0;
        if (dr_set) dr_d = 1'b1;

        int1_d = rw_q[10][7] ^ (rw_q[10][0] & dr_q);  // INTMAP1 @ 0x2A
        int2_d = rw_q[11][7] ^ (rw_q[11][0] & dr_q);  // INTMAP2 @ 0x2B
    end

    // State registers; ncs sync resets low so a frame already open at reset is ignored
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sck_pipe_q  <= 3'b000;
            ncs_pipe_q  <= 3'b000;
            mosi_pipe_q <= 2'b00;
            state_q     <= IDLE;
            is_rd_q     <= 1'b0;
            bit_cnt_q   <= 3'd0;
            shift_in_q  <= 7'd0;
            addr_q      <= 6'd0;
            rd_shift_q  <= 8'd0;
            miso_q      <= 1'b0;
            rw_q        <= '{default: 8'h00};
            x_q <= '0;  y_q <= '0;  z_q <= '0;  t_q <= '0;
            px_q <= '0; py_q <= '0; pz_q <= '0; pt_q <= '0;
            pend_q      <= 1'b0;
            dr_q        <= 1'b0;
            int1_q      <= 1'b0;
            int2_q      <= 1'b0;
        end else begin
            sck_pipe_q  <= sck_pipe_d;
            ncs_pipe_q  <= ncs_pipe_d;
            mosi_pipe_q <= mosi_pipe_d;
            state_q     <= state_d;
            is_rd_q     <= is_rd_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_in_q  <= shift_in_d;
            addr_q      <= addr_d;
            rd_shift_q  <= rd_shift_d;
            miso_q      <= miso_d;
            rw_q        <= rw_d;
            x_q <= x_d;   y_q <= y_d;   z_q <= z_d;   t_q <= t_d;
            px_q <= px_d; py_q <= py_d; pz_q <= pz_d; pt_q <= pt_d;
            pend_q      <= pend_d;
            dr_q        <= dr_d;
            int1_q      <= int1_d;
            int2_q      <= int2_d;
        end
    end

    assign miso_o    = miso_q;
    assign int1_o    = int1_q;
    assign int2_o    = int2_q;
    assign measure_o = (rw_q[13][1:0] == 2'b10);  // POWER_CTL @ 0x2D

endmodule

// File: tb/tb_adxl362_spi_responder.sv
// Scoreboard bench: SPI master tasks push expected miso bytes from a
// register-map model; a monitor assembles miso bytes and compares.
module tb_adxl362_spi_responder;
    localparam int HALF = 50;

    logic clk = 1'b0, nrst = 1'b0;
    logic sck_i = 1'b0, ncs_i = 1'b1, mosi_i = 1'b0;
    logic miso_o, int1_o, int2_o, measure_o;
    logic [11:0] x_i = '0, y_i = '0, z_i = '0, temp_i = '0;
    logic sample_valid_i = 1'b0;

    adxl362_spi_responder dut (
        .clk(clk), .nrst(nrst), .sck_i(sck_i), .ncs_i(ncs_i), .mosi_i(mosi_i),
        .miso_o(miso_o), .x_i(x_i), .y_i(y_i), .z_i(z_i), .temp_i(temp_i),
        .sample_valid_i(sample_valid_i), .int1_o(int1_o), .int2_o(int2_o),
        .measure_o(measure_o)
    );

    always #5 clk = ~clk;

    int n_pass = 0, n_total = 0;

    // Reference model state
    logic [7:0]  m_mem [64];
    logic [11:0] m_s [4];
    logic [11:0] p_s [4];
    logic        m_dr = 1'b0, m_pend = 1'b0;
    logic        ms_en = 1'b0;
    logic [11:0] ms_v [4];
    logic [7:0]  txq [$];
    logic [7:0]  exp_q [$];
    logic [7:0]  wq [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else n_pass++;
    endtask

    function automatic logic [7:0] mread(input int a);
        int v, k;
        logic [7:0] ids [4];
        ids = '{8'hAD, 8'h1D, 8'hF2, 8'h01};
        if (a < 4) return ids[a];
        if (a == 11) return {7'b0, m_dr};
        if (a >= 14 && a <= 21) begin
            k = (a - 14) / 2;
            v = int'(m_s[k]);
            if (v >= 2048) v -= 4096;
            if ((a - 14) % 2 == 0) return 8'(v & 255);
            return 8'((v >>> 8) & 255);
        end
        if (a >= 32 && a <= 46) return m_mem[a];
        return 8'h00;
    endfunction

    function automatic void mwrite(input int a, input logic [7:0] d);
        if (a == 31) begin
            if (d == 8'h52) begin
                for (int i = 32; i <= 46; i++) m_mem[i] = 8'h00;
                m_dr = 1'b0;
            end
        end else if (a >= 32 && a <= 46) m_mem[a] = d;
    endfunction

    task automatic pulse_sample(input logic [11:0] v0, v1, v2, v3);
        @(negedge clk);
        x_i = v0; y_i = v1; z_i = v2; temp_i = v3; sample_valid_i = 1'b1;
        @(negedge clk);
        sample_valid_i = 1'b0;
        if (ncs_i) begin
            m_s = '{v0, v1, v2, v3}; m_dr = 1'b1; m_pend = 1'b0;
        end else begin
            p_s = '{v0, v1, v2, v3}; m_pend = 1'b1;
        end
    endtask

    task automatic run_frame(input int last_bits);
        int nb;
        #2;
        ncs_i = 1'b0;
        #100;
        for (int b = 0; b < txq.size(); b++) begin
            nb = (b == txq.size() - 1) ? last_bits : 8;
            for (int i = 7; i >= 8 - nb; i--) begin
                mosi_i = txq[b][i];
                #HALF sck_i = 1'b1;
                #HALF sck_i = 1'b0;
            end
            if (b == 0 && ms_en) begin
                pulse_sample(ms_v[0], ms_v[1], ms_v[2], ms_v[3]);
                ms_en = 1'b0;
            end
        end
        #HALF;
        ncs_i = 1'b1;
        mosi_i = 1'b0;
        repeat (12) @(posedge clk);
        if (m_pend) begin
            m_s = p_s; m_dr = 1'b1; m_pend = 1'b0;
        end
    endtask

    task automatic spi_read(input int a, input int n);
        int addr;
        txq.delete();
        txq.push_back(8'h0B); txq.push_back(8'(a));
        exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        addr = a % 64;
        // n data bytes, plus one trailing prefetch load that still affects DATA_READY
        for (int i = 0; i <= n; i++) begin
            if (i < n) begin
                txq.push_back(8'($urandom));
                exp_q.push_back(mread(addr));
            end
            if (addr >= 14 && addr <= 21) m_dr = 1'b0;
            addr = (addr + 1) % 64;
        end
        run_frame(8);
    endtask

    task automatic spi_write(input int a, input int last_bits);
        int addr, full;
        txq.delete();
        txq.push_back(8'h0A); txq.push_back(8'(a));
        foreach (wq[i]) txq.push_back(wq[i]);
        full = (last_bits < 8) ? wq.size() - 1 : wq.size();
        for (int i = 0; i < 2 + full; i++) exp_q.push_back(8'h00);
        addr = a % 64;
        for (int i = 0; i < full; i++) begin
            mwrite(addr, wq[i]);
            addr = (addr + 1) % 64;
        end
        run_frame(last_bits);
    endtask

    task automatic spi_bad(input logic [7:0] cmd, input int n);
        txq.delete();
        txq.push_back(cmd);
        exp_q.push_back(8'h00);
        for (int i = 0; i < n; i++) begin
            txq.push_back(8'($urandom));
            exp_q.push_back(8'h00);
        end
        run_frame(8);
    endtask

    task automatic chk_side();
        repeat (3) @(negedge clk);
        chk("int1", int1_o, m_mem[42][7] ^ (m_mem[42][0] & m_dr));
        chk("int2", int2_o, m_mem[43][7] ^ (m_mem[43][0] & m_dr));
        chk("measure", measure_o, m_mem[45][1:0] == 2'b10);
    endtask

    // Monitor: assemble each miso byte on sck rising edges and score it
    initial begin
        int nb;
        logic [7:0] sh;
        logic [7:0] e;
        nb = 0;
        sh = 8'h00;
        forever begin
            @(posedge sck_i or posedge ncs_i);
            if (ncs_i) nb = 0;
            else begin
                sh = {sh[6:0], miso_o};
                nb++;
                if (nb == 8) begin
                    nb = 0;
                    if (exp_q.size() == 0) begin
                        n_total++;
                        $display("FAIL miso_extra: got %0h expected no byte", sh);
                    end else begin
                        e = exp_q.pop_front();
                        chk("miso", sh, e);
                    end
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int op, a, n, lb;
        foreach (m_mem[i]) m_mem[i] = 8'h00;
        m_s = '{default: 12'h0};
        p_s = '{default: 12'h0};
        repeat (4) @(negedge clk);
        chk("rst_miso", miso_o, 0);
        chk("rst_int1", int1_o, 0);
        chk("rst_int2", int2_o, 0);
        chk("rst_measure", measure_o, 0);
        nrst = 1'b1;
        repeat (5) @(negedge clk);

        // ID burst
        spi_read(8'h00, 4);
        // Write then read back; POWER_CTL=measure
        wq = '{8'h02}; spi_write(8'h2D, 8);
        wq = '{8'h01}; spi_write(8'h2A, 8);
        spi_read(8'h2D, 1);
        spi_read(8'h2A, 1);
        chk_side();
        // Sample and interrupt
        pulse_sample(12'h801, 12'($urandom), 12'($urandom), 12'h0FF);
        chk_side();
        spi_read(8'h0E, 2);
        chk_side();
        spi_read(8'h14, 2);
        // Coherency: new sample mid-burst is deferred to frame end
        pulse_sample(12'($urandom), 12'($urandom), 12'($urandom), 12'($urandom));
        ms_v = '{12'($urandom), 12'($urandom), 12'($urandom), 12'($urandom)};
        ms_en = 1'b1;
        spi_read(8'h0E, 8);
        chk_side();
        spi_read(8'h0B, 1);
        spi_read(8'h0E, 8);
        // Wraparound from 0x3F into read-only 0x00
        wq = '{8'h5A, 8'h33}; spi_write(8'h3F, 8);
        spi_read(8'h3F, 2);
        // Unknown command
        spi_bad(8'h0D, 3);
        // Partial byte is discarded
        wq = '{8'hFF}; spi_write(8'h2B, 5);
        spi_read(8'h2B, 1);
        // Soft reset: only 0x52 clears
        wq = '{8'h52}; spi_write(8'h1F, 8);
        spi_read(8'h20, 15);
        chk_side();
        wq = '{8'h81, 8'h80}; spi_write(8'h2A, 8);
        wq = '{8'h51}; spi_write(8'h1F, 8);
        spi_read(8'h1F, 16);
        chk_side();

        // Randomized traffic
        for (int it = 0; it < 40; it++) begin
            op = $urandom_range(0, 3);
            case (op)
                0: begin
                    a = $urandom_range(0, 255);
                    n = $urandom_range(1, 4);
                    if ($urandom_range(0, 3) == 0) begin
                        ms_v = '{12'($urandom), 12'($urandom), 12'($urandom), 12'($urandom)};
                        ms_en = 1'b1;
                    end
                    spi_read(a, n);
                end
                1: begin
                    a = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(8'h1E, 8'h2F);
                    n = $urandom_range(1, 3);
                    wq.delete();
                    for (int i = 0; i < n; i++)
                        wq.push_back(($urandom_range(0, 3) == 0) ? 8'h52 : 8'($urandom));
                    lb = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 7) : 8;
                    spi_write(a, lb);
                end
                2: pulse_sample(12'($urandom), 12'($urandom), 12'($urandom), 12'($urandom));
                default: spi_bad(8'($urandom_range(8'h0C, 8'hFF)), $urandom_range(1, 3));
            endcase
            chk_side();
        end

        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
